imem_loader: RTL and testbench

- Writer side of the instruction-memory write port on the IF stage (W_Ins / WE plus a word address).
- Receives a byte stream over a valid/ready handshake and packs it into 32-bit instructions. The stream is a length header followed by instruction words.
- Writes each instruction into IMem at consecutive word addresses, then releases the core from hold.
- Sits between a host/serial front end and the IF stage, replacing IMem.txt preloading in hardware runs.

---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/imem_loader_byte_packer.sv | 36 +++
 rtl/imem_loader.sv | 113 +++++++++++
 tb/tb_imem_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and
// byte-stream framing constants.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam int BYTES_PER_WORD = 4;

    // Header and instruction words arrive most-significant byte first.
    localparam bit HDR_MSB_FIRST = 1'b1;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles accepted stream bytes into 32-bit words; word_valid marks the
// cycle in which the final byte of a word is being accepted.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        clr,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  byte_cnt_reg;
    logic [23:0] shift_reg;

    // The completed word includes the byte being accepted this cycle, so the
    // FSM can capture it on the same edge without an extra stage.
    assign word       = HDR_MSB_FIRST ? {shift_reg, byte_in} : {byte_in, shift_reg};
    assign word_valid = accept && (byte_cnt_reg == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            byte_cnt_reg <= '0;
            shift_reg    <= '0;
        end else if (clr) begin
            byte_cnt_reg <= '0;
            shift_reg    <= '0;
        end else if (accept) begin
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            shift_reg    <= HDR_MSB_FIRST ? word[23:0] : word[31:8];
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed instruction image into IMem through its write
// port, holding the core in reset until the whole image has been written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 8,
    parameter int BASE_ADDR   = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [31:0]       W_Ins,
    output logic [ADDR_W-1:0] W_Addr,
    output logic              WE,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int               CNT_W = $clog2(DEPTH_WORDS + 1);
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   remaining_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [31:0]        ins_reg;
    logic               core_hold_reg, core_hold_next;
    logic               start_ok;
    logic               accept;
    logic               word_valid;
    logic [31:0]        packed_word;

    assign start_ok = start && (state_reg == S_IDLE || state_reg == S_DONE ||
                                state_reg == S_ERR);
    assign accept   = rx_valid && rx_ready;

    imem_loader_byte_packer u_packer (
        .CLK        (CLK),
        .RST        (RST),
        .clr        (start_ok),
        .accept     (accept),
        .byte_in    (rx_data),
        .word       (packed_word),
        .word_valid (word_valid)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_next = S_HDR;
            end
            S_HDR: begin
                if (word_valid) begin
                    if (packed_word == 32'd0)                    state_next = S_DONE;
                    else if (packed_word > 32'(DEPTH_WORDS))     state_next = S_ERR;
                    else                                         state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (word_valid) state_next = S_WRITE;
            end
            S_WRITE: begin
                state_next = (remaining_reg == CNT_W'(1)) ? S_DONE : S_DATA;
            end
            default: state_next = S_IDLE;
        endcase
        // Release lags S_DONE entry by one cycle; a restart re-asserts at once.
        core_hold_next = !(state_reg == S_DONE && state_next == S_DONE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg     <= S_IDLE;
            remaining_reg <= '0;
            addr_reg      <= BASE;
            ins_reg       <= '0;
            core_hold_reg <= 1'b1;
        end else begin
            state_reg     <= state_next;
            core_hold_reg <= core_hold_next;

            if (start_ok)
                addr_reg <= BASE;
            else if (state_reg == S_WRITE)
                addr_reg <= addr_reg + ADDR_W'(1);

            if (state_reg == S_HDR && word_valid)
                remaining_reg <= packed_word[CNT_W-1:0];
            else if (state_reg == S_WRITE)
                remaining_reg <= remaining_reg - CNT_W'(1);

            if (state_reg == S_DATA && word_valid)
                ins_reg <= packed_word;
        end
    end

    assign rx_ready  = (state_reg == S_HDR) || (state_reg == S_DATA);
    assign WE        = (state_reg == S_WRITE);
    assign busy      = (state_reg == S_HDR) || (state_reg == S_DATA) ||
                       (state_reg == S_WRITE);
    assign done      = (state_reg == S_DONE);
    assign err       = (state_reg == S_ERR);
    assign core_hold = core_hold_reg;
    assign W_Ins     = ins_reg;
    assign W_Addr    = addr_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected IMem writes,
// a negedge monitor pops and compares them whenever WE is seen.
module tb_imem_loader;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [31:0] W_Ins;
    logic [7:0]  W_Addr;
    logic        WE;
    logic        core_hold;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;
    int we_cnt  = 0;
    int acc_cnt = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    imem_loader #(.DEPTH_WORDS(256), .ADDR_W(8), .BASE_ADDR(0)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .W_Ins     (W_Ins),
        .W_Addr    (W_Addr),
        .WE        (WE),
        .core_hold (core_hold),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    // Bytes consumed by the DUT (inputs change only on negedges).
    always @(posedge CLK) begin
        if (rx_valid && rx_ready) acc_cnt++;
    end

    // Scoreboard monitor.
    always @(negedge CLK) begin
        if (WE) begin
            we_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_we: got addr=%h data=%h expected no write", W_Addr, W_Ins);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("we_addr", {24'd0, W_Addr}, {24'd0, e.addr});
                check("we_data", W_Ins, e.data);
                check("we_rx_ready_low", {31'd0, rx_ready}, 32'd0);
            end
        end
    end

    // All tasks are entered and left at a negedge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL rx_ready_timeout: got rx_ready=0 for 50 cycles expected 1");
        end
        @(negedge CLK);
        rx_valid = 1'b0;
        repeat (gap) @(negedge CLK);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic expect_write(input logic [7:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!(done && !core_hold) && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check({name, "_done"}, {31'd0, done}, 32'd1);
        check({name, "_core_hold"}, {31'd0, core_hold}, 32'd0);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
        check({name, "_queue_empty"}, exp_q.size(), 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
        check({name, "_we"}, {31'd0, WE}, 32'd0);
        check({name, "_w_ins"}, W_Ins, 32'd0);
        check({name, "_w_addr"}, {24'd0, W_Addr}, 32'd0);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
        check({name, "_done"}, {31'd0, done}, 32'd0);
        check({name, "_err"}, {31'd0, err}, 32'd0);
        check({name, "_core_hold"}, {31'd0, core_hold}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int we0, acc0;

        // Reset state
        repeat (2) @(negedge CLK);
        check_reset_outputs("reset");
        RST = 1'b1;
        @(negedge CLK);

        // Two-word load, back-to-back bytes; second word's first byte waits out S_WRITE
        we0 = we_cnt;
        acc0 = acc_cnt;
        expect_write(8'd0, 32'h20080005);
        expect_write(8'd1, 32'h20090007);
        pulse_start();
        check("two_busy", {31'd0, busy}, 32'd1);
        send_word(32'h00000002, 0);
        send_word(32'h20080005, 0);
        send_word(32'h20090007, 0);
        wait_done("two");
        check("two_we_count", we_cnt - we0, 32'd2);
        check("two_bytes_consumed", acc_cnt - acc0, 32'd12);
        check("two_w_ins_held", W_Ins, 32'h20090007);

        // Zero-length load
        we0 = we_cnt;
        pulse_start();
        check("zero_restart_core_hold", {31'd0, core_hold}, 32'd1);
        check("zero_restart_done", {31'd0, done}, 32'd0);
        send_word(32'h00000000, 0);
        check("zero_done", {31'd0, done}, 32'd1);
        @(negedge CLK);
        check("zero_core_hold", {31'd0, core_hold}, 32'd0);
        check("zero_we_count", we_cnt - we0, 32'd0);

        // Oversize header (257)
        we0 = we_cnt;
        pulse_start();
        send_word(32'h00000101, 0);
        check("over_err", {31'd0, err}, 32'd1);
        check("over_done", {31'd0, done}, 32'd0);
        check("over_core_hold", {31'd0, core_hold}, 32'd1);
        check("over_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("over_busy", {31'd0, busy}, 32'd0);
        acc0 = acc_cnt;
        rx_data = 8'hAA;
        rx_valid = 1'b1;
        repeat (3) @(negedge CLK);
        rx_valid = 1'b0;
        check("over_no_consume", acc_cnt - acc0, 32'd0);
        check("over_we_count", we_cnt - we0, 32'd0);
        pulse_start();
        check("over_restart_err", {31'd0, err}, 32'd0);
        check("over_restart_rx_ready", {31'd0, rx_ready}, 32'd1);
        send_word(32'h00000000, 0);
        wait_done("over_recover");

        // Back-pressure: valid toggles every other cycle
        we0 = we_cnt;
        acc0 = acc_cnt;
        expect_write(8'd0, 32'h8C0A0004);
        pulse_start();
        send_word(32'h00000001, 1);
        send_word(32'h8C0A0004, 1);
        wait_done("bp");
        check("bp_we_count", we_cnt - we0, 32'd1);
        check("bp_bytes_consumed", acc_cnt - acc0, 32'd8);

        // Reset mid-load after 6 bytes
        we0 = we_cnt;
        pulse_start();
        send_word(32'h00000002, 0);
        send_byte(8'h20, 0);
        send_byte(8'h08, 0);
        #2 RST = 1'b0;
        #1 check_reset_outputs("midrst");
        repeat (3) @(negedge CLK);
        check("midrst_we_count", we_cnt - we0, 32'd0);
        RST = 1'b1;
        @(negedge CLK);
        expect_write(8'd0, 32'h11223344);
        pulse_start();
        send_word(32'h00000001, 0);
        send_word(32'h11223344, 0);
        wait_done("fresh");

        // start during S_DATA is ignored; start after done restarts at BASE
        we0 = we_cnt;
        expect_write(8'd0, 32'hA1B2C3D4);
        expect_write(8'd1, 32'h0F1E2D3C);
        pulse_start();
        send_word(32'h00000002, 0);
        send_word(32'hA1B2C3D4, 0);
        send_byte(8'h0F, 0);
        pulse_start();
        check("ign_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h1E, 0);
        send_byte(8'h2D, 0);
        send_byte(8'h3C, 0);
        wait_done("ign");
        check("ign_we_count", we_cnt - we0, 32'd2);
        expect_write(8'd0, 32'hDEADBEEF);
        pulse_start();
        check("restart_core_hold", {31'd0, core_hold}, 32'd1);
        check("restart_done", {31'd0, done}, 32'd0);
        send_word(32'h00000001, 0);
        send_word(32'hDEADBEEF, 0);
        wait_done("restart");

        repeat (2) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
